bus_config_ctrl: RTL and testbench

BUS_CONFIG_CTRL -- requirements
Module: bus_config_ctrl

---
 rtl/bus_config_ctrl.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_bus_config_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_config_ctrl.sv
// bus_config_ctrl: push-button/switch driven configuration sequencer for a set of bus masters.
// Define CFG_DEBOUNCE_EN to add a stable-level filter (DEBOUNCE_CYCLES) behind the button synchronisers.
module bus_config_ctrl #(
  parameter int MASTER_COUNT    = 2,
  parameter int SLAVE_SEL_W     = 2,
  parameter int ADDR_WIDTH      = 12,
  parameter int DATA_WIDTH      = 16,
  parameter int MAX_WRITE_DEPTH = 16,
  parameter int SW_WIDTH        = 18,
  parameter int DEBOUNCE_CYCLES = 500000,
  localparam int MI_W = (MASTER_COUNT > 1) ? $clog2(MASTER_COUNT) : 1,
  localparam int WA_W = $clog2(MAX_WRITE_DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  jump_stateN,
  input  logic                                  jump_next_addrN,
  input  logic [SW_WIDTH-1:0]                   SW,
  output logic [MASTER_COUNT*SLAVE_SEL_W-1:0]   master_slave_sel,
  output logic [MASTER_COUNT-1:0]               master_rw,
  output logic [MASTER_COUNT-1:0]               master_ext_wr,
  output logic [MASTER_COUNT*ADDR_WIDTH-1:0]    start_addr,
  output logic [MASTER_COUNT*ADDR_WIDTH-1:0]    end_addr,
  output logic                                  ext_wr_valid,
  output logic [MI_W-1:0]                       ext_wr_master,
  output logic [WA_W-1:0]                       ext_wr_addr,
  output logic [DATA_WIDTH-1:0]                 ext_wr_data,
  output logic [2:0]                            cfg_state,
  output logic                                  cfg_ready,
  output logic                                  cfg_err,
  output logic                                  com_start
);

  if ((MASTER_COUNT * SLAVE_SEL_W > SW_WIDTH) || (ADDR_WIDTH > SW_WIDTH) ||
      (DATA_WIDTH > SW_WIDTH)) begin : g_param_check
    $error("bus_config_ctrl: a configuration field is wider than SW_WIDTH");
  end

  typedef enum logic [2:0] {
    ST_SLAVE_SEL  = 3'd0,
    ST_RW_SEL     = 3'd1,
    ST_EXT_SEL    = 3'd2,
    ST_EXT_WRITE  = 3'd3,
    ST_START_ADDR = 3'd4,
    ST_END_ADDR   = 3'd5,
    ST_READY      = 3'd6
  } state_e;

  // bit 0 = state button, bit 1 = next-address button; buttons idle high
  logic [1:0] btn_raw_s, sync1_r, sync2_r, press_r;
  logic       state_press_s, next_press_s;
  logic       sw_unused_s;

  assign btn_raw_s     = {jump_next_addrN, jump_stateN};
  assign state_press_s = press_r[0];
  assign next_press_s  = press_r[1] & ~press_r[0];
  assign sw_unused_s   = ^SW;

  // two-flop synchroniser for the raw buttons
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 2'b11;
      sync2_r <= 2'b11;
    end else begin
      sync1_r <= btn_raw_s;
      sync2_r <= sync1_r;
    end
  end

`ifdef CFG_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0]      level_r;
  logic [DB_W-1:0] db_cnt_r [2];

  // accept a new level after it has been stable for DEBOUNCE_CYCLES samples; pulse on 1->0
  always_ff @(posedge clk) begin
    if (rst) begin
      level_r <= 2'b11;
      press_r <= 2'b00;
      for (int b = 0; b < 2; b++) db_cnt_r[b] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (sync2_r[b] == level_r[b]) begin
          db_cnt_r[b] <= '0;
          press_r[b]  <= 1'b0;
        end else if (db_cnt_r[b] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt_r[b] <= '0;
          level_r[b]  <= sync2_r[b];
          press_r[b]  <= level_r[b];
        end else begin
          db_cnt_r[b] <= db_cnt_r[b] + DB_W'(1);
          press_r[b]  <= 1'b0;
        end
      end
    end
  end
`else
  logic [1:0] prev_r;

  // falling-edge detect on the synchronised buttons
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_r  <= 2'b11;
      press_r <= 2'b00;
    end else begin
      prev_r  <= sync2_r;
      press_r <= prev_r & ~sync2_r;
    end
  end
`endif

  state_e                              state_r, state_s;
  logic [MI_W-1:0]                     idx_r, idx_s, first_idx_s, next_idx_s;
  logic [WA_W-1:0]                     waddr_r, waddr_s;
  logic                                first_s, next_found_s;
  logic [MASTER_COUNT*SLAVE_SEL_W-1:0] sel_s;
  logic [MASTER_COUNT-1:0]             rw_s, ext_s;
  logic [MASTER_COUNT*ADDR_WIDTH-1:0]  start_s, end_s;
  logic                                wr_valid_s, ready_s, err_s, com_start_s;
  logic [MI_W-1:0]                     wr_master_s;
  logic [WA_W-1:0]                     wr_addr_s;
  logic [DATA_WIDTH-1:0]               wr_data_s;

  // next-state and next-output logic
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    waddr_s      = waddr_r;
    sel_s        = master_slave_sel;
    rw_s         = master_rw;
    ext_s        = master_ext_wr;
    start_s      = start_addr;
    end_s        = end_addr;
    wr_valid_s   = 1'b0;
    wr_master_s  = ext_wr_master;
    wr_addr_s    = ext_wr_addr;
    wr_data_s    = ext_wr_data;
    ready_s      = cfg_ready;
    err_s        = cfg_err;
    com_start_s  = 1'b0;
    first_s      = 1'b0;
    first_idx_s  = '0;
    next_found_s = 1'b0;
    next_idx_s   = '0;

    // descending scan leaves the lowest qualifying master selected
    for (int i = MASTER_COUNT - 1; i >= 0; i--) begin
      if (SW[i]) begin
        first_s     = 1'b1;
        first_idx_s = MI_W'(i);
      end else begin
      end
      if (master_ext_wr[i] && (i > int'(idx_r))) begin
        next_found_s = 1'b1;
        next_idx_s   = MI_W'(i);
      end else begin
      end
    end

    case (state_r)
      ST_SLAVE_SEL: begin
        if (state_press_s) begin
          sel_s   = SW[MASTER_COUNT*SLAVE_SEL_W-1:0];
          state_s = ST_RW_SEL;
        end else begin
        end
      end
      ST_RW_SEL: begin
        if (state_press_s) begin
          rw_s    = SW[MASTER_COUNT-1:0];
          state_s = ST_EXT_SEL;
        end else begin
        end
      end
      ST_EXT_SEL: begin
        if (state_press_s) begin
          ext_s   = SW[MASTER_COUNT-1:0];
          waddr_s = '0;
          idx_s   = first_s ? first_idx_s : '0;
          state_s = first_s ? ST_EXT_WRITE : ST_START_ADDR;
        end else begin
        end
      end
      ST_EXT_WRITE: begin
        if (state_press_s || next_press_s) begin
          wr_valid_s  = 1'b1;
          wr_master_s = idx_r;
          wr_addr_s   = waddr_r;
          wr_data_s   = SW[DATA_WIDTH-1:0];
        end else begin
        end
        if (state_press_s) begin
          waddr_s = '0;
          idx_s   = next_found_s ? next_idx_s : '0;
          state_s = next_found_s ? ST_EXT_WRITE : ST_START_ADDR;
        end else if (next_press_s) begin
          waddr_s = (waddr_r == WA_W'(MAX_WRITE_DEPTH - 1)) ? waddr_r : waddr_r + WA_W'(1);
        end else begin
        end
      end
      ST_START_ADDR: begin
        if (state_press_s) begin
          start_s[int'(idx_r)*ADDR_WIDTH +: ADDR_WIDTH] = SW[ADDR_WIDTH-1:0];
          if (idx_r == MI_W'(MASTER_COUNT - 1)) begin
            idx_s   = '0;
            state_s = ST_END_ADDR;
          end else begin
            idx_s = idx_r + MI_W'(1);
          end
        end else begin
        end
      end
      ST_END_ADDR: begin
        if (state_press_s) begin
          // an end below the start is clamped to the start and flagged
          if (SW[ADDR_WIDTH-1:0] < start_addr[int'(idx_r)*ADDR_WIDTH +: ADDR_WIDTH]) begin
            end_s[int'(idx_r)*ADDR_WIDTH +: ADDR_WIDTH] = start_addr[int'(idx_r)*ADDR_WIDTH +: ADDR_WIDTH];
            err_s = 1'b1;
          end else begin
            end_s[int'(idx_r)*ADDR_WIDTH +: ADDR_WIDTH] = SW[ADDR_WIDTH-1:0];
          end
          if (idx_r == MI_W'(MASTER_COUNT - 1)) begin
            idx_s   = '0;
            ready_s = 1'b1;
            state_s = ST_READY;
          end else begin
            idx_s = idx_r + MI_W'(1);
          end
        end else begin
        end
      end
      ST_READY: begin
        com_start_s = state_press_s;
      end
      default: begin
        state_s = ST_SLAVE_SEL;
      end
    endcase
  end

  // state, index and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= ST_SLAVE_SEL;
      idx_r            <= '0;
      waddr_r          <= '0;
      master_slave_sel <= '0;
      master_rw        <= '0;
      master_ext_wr    <= '0;
      start_addr       <= '0;
      end_addr         <= '0;
      ext_wr_valid     <= 1'b0;
      ext_wr_master    <= '0;
      ext_wr_addr      <= '0;
      ext_wr_data      <= '0;
      cfg_ready        <= 1'b0;
      cfg_err          <= 1'b0;
      com_start        <= 1'b0;
    end else begin
      state_r          <= state_s;
      idx_r            <= idx_s;
      waddr_r          <= waddr_s;
      master_slave_sel <= sel_s;
      master_rw        <= rw_s;
      master_ext_wr    <= ext_s;
      start_addr       <= start_s;
      end_addr         <= end_s;
      ext_wr_valid     <= wr_valid_s;
      ext_wr_master    <= wr_master_s;
      ext_wr_addr      <= wr_addr_s;
      ext_wr_data      <= wr_data_s;
      cfg_ready        <= ready_s;
      cfg_err          <= err_s;
      com_start        <= com_start_s;
    end
  end

  assign cfg_state = state_r;

endmodule

// File: tb/tb_bus_config_ctrl.sv
// Directed, table-driven bench for bus_config_ctrl (DEBOUNCE_CYCLES=4, other parameters default).
module tb_bus_config_ctrl;

`ifdef CFG_DEBOUNCE_EN
  localparam int         PULSE_LAT    = 6;
  localparam logic [2:0] GLITCH_STATE = 3'd0;
`else
  localparam int         PULSE_LAT    = 3;
  localparam logic [2:0] GLITCH_STATE = 3'd1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_stateN, jump_next_addrN;
  logic [17:0] SW;
  logic [3:0]  master_slave_sel;
  logic [1:0]  master_rw, master_ext_wr;
  logic [23:0] start_addr, end_addr;
  logic        ext_wr_valid;
  logic [0:0]  ext_wr_master;
  logic [3:0]  ext_wr_addr;
  logic [15:0] ext_wr_data;
  logic [2:0]  cfg_state;
  logic        cfg_ready, cfg_err, com_start;

  bus_config_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .jump_stateN(jump_stateN), .jump_next_addrN(jump_next_addrN),
    .SW(SW), .master_slave_sel(master_slave_sel), .master_rw(master_rw),
    .master_ext_wr(master_ext_wr), .start_addr(start_addr), .end_addr(end_addr),
    .ext_wr_valid(ext_wr_valid), .ext_wr_master(ext_wr_master), .ext_wr_addr(ext_wr_addr),
    .ext_wr_data(ext_wr_data), .cfg_state(cfg_state), .cfg_ready(cfg_ready),
    .cfg_err(cfg_err), .com_start(com_start)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] B_ST = 2'b01, B_NX = 2'b10, B_BOTH = 2'b11;

  typedef struct {
    logic [17:0] sw;
    logic [1:0]  btn;
    logic [2:0]  exp_state;
    int          exp_wr;
    bit          chk_wr;
    logic [20:0] exp_last;  // {master, addr, data}
  } vec_t;

  vec_t        vecs[$];
  logic [20:0] wr_q[$];
  int          com_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(negedge clk) begin
    if (ext_wr_valid) wr_q.push_back({ext_wr_master, ext_wr_addr, ext_wr_data});
    if (com_start) com_cnt++;
  end

  function automatic vec_t mk(input logic [17:0] sw, input logic [1:0] btn, input logic [2:0] st,
                              input int wr, input bit chk, input logic [20:0] last);
    vec_t v;
    v.sw = sw; v.btn = btn; v.exp_state = st; v.exp_wr = wr; v.chk_wr = chk; v.exp_last = last;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [1:0] b, input logic [17:0] sw);
    @(negedge clk);
    SW = sw;
    jump_stateN = ~b[0];
    jump_next_addrN = ~b[1];
    repeat (10) @(negedge clk);
    jump_stateN = 1'b1;
    jump_next_addrN = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " cfg outputs"},
          {master_slave_sel, master_rw, master_ext_wr, start_addr, end_addr,
           cfg_state, cfg_ready, cfg_err, com_start}, 128'd0);
    check({tag, " write outputs"},
          {ext_wr_valid, ext_wr_master, ext_wr_addr, ext_wr_data}, 128'd0);
  endtask

  initial begin
    logic [3:0] a;
    rst = 1'b1;
    jump_stateN = 1'b1;
    jump_next_addrN = 1'b1;
    SW = 18'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_all_zero("reset");

    // short glitch on the state button
    @(negedge clk);
    jump_stateN = 1'b0;
    repeat (2) @(negedge clk);
    jump_stateN = 1'b1;
    repeat (15) @(negedge clk);
    check("glitch state", cfg_state, GLITCH_STATE);
    do_reset();
    check("reset again state", cfg_state, 3'd0);

    vecs.push_back(mk(18'h00001, B_ST, 3'd1, 0, 1'b0, 21'd0));
    vecs.push_back(mk(18'h00002, B_ST, 3'd2, 0, 1'b0, 21'd0));
    vecs.push_back(mk(18'h00003, B_ST, 3'd3, 0, 1'b0, 21'd0));
    vecs.push_back(mk(18'h0BEEF, B_NX, 3'd3, 1, 1'b1, {1'b0, 4'd0, 16'hBEEF}));
    vecs.push_back(mk(18'h01234, B_ST, 3'd3, 2, 1'b1, {1'b0, 4'd1, 16'h1234}));
    for (int k = 0; k < 17; k++) begin
      a = (k > 15) ? 4'd15 : 4'(k);
      vecs.push_back(mk(18'h000AA, B_NX, 3'd3, 3 + k, 1'b1, {1'b1, a, 16'h00AA}));
    end
    vecs.push_back(mk(18'h00055, B_BOTH, 3'd4, 20, 1'b1, {1'b1, 4'd15, 16'h0055}));
    vecs.push_back(mk(18'h00077, B_NX, 3'd4, 20, 1'b0, 21'd0));
    vecs.push_back(mk(18'h00005, B_ST, 3'd4, 20, 1'b0, 21'd0));
    vecs.push_back(mk(18'h00000, B_ST, 3'd5, 20, 1'b0, 21'd0));
    vecs.push_back(mk(18'h00009, B_ST, 3'd5, 20, 1'b0, 21'd0));
    vecs.push_back(mk(18'h00000, B_ST, 3'd6, 20, 1'b0, 21'd0));
    vecs.push_back(mk(18'h00000, B_NX, 3'd6, 20, 1'b0, 21'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      press(vecs[i].btn, vecs[i].sw);
      check($sformatf("vec%0d state", i), cfg_state, vecs[i].exp_state);
      check($sformatf("vec%0d write count", i), wr_q.size(), vecs[i].exp_wr);
      if (vecs[i].chk_wr)
        check($sformatf("vec%0d last write", i),
              (wr_q.size() > 0) ? wr_q[wr_q.size() - 1] : 21'd0, vecs[i].exp_last);
    end

    check("slave sel", master_slave_sel, 4'h1);
    check("rw", master_rw, 2'b10);
    check("ext wr", master_ext_wr, 2'b11);
    check("start addr", start_addr, 24'h000005);
    check("end addr", end_addr, 24'h000009);
    check("ready/err", {cfg_ready, cfg_err}, 2'b10);
    check("com_start idle", com_cnt, 0);
    press(B_ST, 18'd0);
    check("com_start pulse count", com_cnt, 1);
    check("ready hold state", cfg_state, 3'd6);

    // reset while a next-address write is in flight
    do_reset();
    press(B_ST, 18'd0);
    press(B_ST, 18'd0);
    press(B_ST, 18'd1);
    check("abort setup state", cfg_state, 3'd3);
    SW = 18'h04321;
    @(negedge clk);
    jump_next_addrN = 1'b0;
    repeat (PULSE_LAT) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    jump_next_addrN = 1'b1;
    @(negedge clk);
    check("abort no valid", ext_wr_valid, 1'b0);
    check("abort state", cfg_state, 3'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check_all_zero("abort");
    check("abort write count", wr_q.size(), 20);

    // end address below start clamps and flags
    press(B_ST, 18'd0);
    press(B_ST, 18'd0);
    press(B_ST, 18'd0);
    check("no ext state", cfg_state, 3'd4);
    press(B_ST, 18'd5);
    press(B_ST, 18'd0);
    press(B_ST, 18'd3);
    press(B_ST, 18'd0);
    check("err state", cfg_state, 3'd6);
    check("err start addr", start_addr, 24'h000005);
    check("err end addr", end_addr, 24'h000005);
    check("err ready/err", {cfg_ready, cfg_err}, 2'b11);
    check("err write count", wr_q.size(), 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
